// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
//   Shared definitions for the countdown controller:
//     - interval_e     : encoding of the four programmable time parameters
//     - DEF_*          : power-up / reset values of those parameters (seconds)
//     - state_e        : countdown FSM states
//     - default_param  : maps a parameter index to its reset value
//     - sat_dec        : 4-bit decrement that holds at zero
// -----------------------------------------------------------------------------
package alarm_pkg;

  typedef enum logic [1:0] {
    INTV_ARM_DELAY       = 2'd0,
    INTV_DRIVER_DELAY    = 2'd1,
    INTV_PASSENGER_DELAY = 2'd2,
    INTV_ALARM_ON        = 2'd3
  } interval_e;

  localparam int NUM_PARAMS = 4;

  localparam logic [3:0] DEF_ARM_DELAY       = 4'd6;
  localparam logic [3:0] DEF_DRIVER_DELAY    = 4'd8;
  localparam logic [3:0] DEF_PASSENGER_DELAY = 4'd15;
  localparam logic [3:0] DEF_ALARM_ON        = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Reset value of the parameter register selected by idx.
  function automatic logic [3:0] default_param(input logic [1:0] idx);
    logic [3:0] val;
    case (idx)
      INTV_ARM_DELAY:       val = DEF_ARM_DELAY;
      INTV_DRIVER_DELAY:    val = DEF_DRIVER_DELAY;
      INTV_PASSENGER_DELAY: val = DEF_PASSENGER_DELAY;
      default:              val = DEF_ALARM_ON;
    endcase
    return val;
  endfunction

  // The seconds counter must never wrap from 0 to 15.
  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// -----------------------------------------------------------------------------
// countdown_ctrl_if
//   Bundles the control and status signals of countdown_ctrl.
//   master : the side that requests countdowns and reprograms parameters
//   slave  : the countdown controller itself
//   Signals:
//     start_timer    - level, any high cycle (re)starts the countdown
//     interval       - parameter used for the countdown / idle display
//     reprogram      - debounced level, rising edge writes a parameter
//     time_param_sel - parameter index written on reprogram
//     time_value     - new parameter value in seconds (0 is ignored)
//     expired        - one-cycle pulse at the end of a countdown
//     one_hz_enable  - one-cycle tick every CLK_HZ clocks
//     half_hz_enable - square wave toggling on every one_hz_enable
//     value_display  - seconds remaining, or selected parameter when idle
//     busy           - high while counting
// -----------------------------------------------------------------------------
interface countdown_ctrl_if;

  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       one_hz_enable;
  logic       half_hz_enable;
  logic [3:0] value_display;
  logic       busy;

  modport master (
    output start_timer, interval, reprogram, time_param_sel, time_value,
    input  expired, one_hz_enable, half_hz_enable, value_display, busy
  );

  modport slave (
    input  start_timer, interval, reprogram, time_param_sel, time_value,
    output expired, one_hz_enable, half_hz_enable, value_display, busy
  );

endinterface

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Free-running prescaler producing a one-cycle tick every CLK_HZ clocks,
//   plus a half-rate square wave that toggles on every tick.
//   Ports:
//     clock          - system clock, rising edge
//     reset          - synchronous, active-high
//     clear          - synchronous prescaler clear (restarts the second)
//     one_hz_enable  - high while the prescaler sits at CLK_HZ-1
//     half_hz_enable - toggles on every one_hz_enable, never cleared by clear
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic one_hz_enable,
  output logic half_hz_enable
);

  localparam int            CW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLK_HZ - 1);

  logic [CW-1:0] presc_q, presc_d;
  logic          half_q, half_d;

  assign one_hz_enable  = (presc_q == TERMINAL);
  assign half_hz_enable = half_q;

  // Next-state for the prescaler and the half-rate toggle. A clear wins over
  // the normal wrap so a fresh countdown always gets a full first second.
  always_comb begin
    presc_d = presc_q + CW'(1);
    if (clear || one_hz_enable) begin
      presc_d = '0;
    end
    half_d = half_q ^ one_hz_enable;
  end

  // Prescaler and toggle registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      half_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      half_q  <= half_d;
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
//   Programmable seconds countdown for the alarm controller. Four 4-bit time
//   parameters are held in registers that can be rewritten at run time; a
//   start request loads the selected parameter and counts it down once per
//   second, pulsing expired when it reaches zero.
//   Ports:
//     clock - system clock, rising edge
//     reset - synchronous, active-high; overrides start and reprogram
//     bus   - countdown_ctrl_if.slave, see the interface for signal meanings
//   Parameter:
//     CLK_HZ - clock cycles per one-second tick
// -----------------------------------------------------------------------------
module countdown_ctrl #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic                   clock,
  input  logic                   reset,
  countdown_ctrl_if.slave        bus
);

  import alarm_pkg::*;

  logic                             one_hz;
  logic                             half_hz;

  state_e                           state_q, state_d;
  logic [3:0]                       remaining_q, remaining_d;
  logic                             expired_q, expired_d;
  logic                             busy_q, busy_d;
  logic                             reprog_q;
  logic [NUM_PARAMS-1:0][3:0]       params_q, params_d;
  logic                             param_wr;

  // The prescaler is cleared by the same start request that loads the
  // counter, so the first decrement comes a full second after start.
  tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clock          (clock),
    .reset          (reset),
    .clear          (bus.start_timer),
    .one_hz_enable  (one_hz),
    .half_hz_enable (half_hz)
  );

  assign param_wr = bus.reprogram && !reprog_q && (bus.time_value != 4'd0);

  // Parameter write path: only the rising edge of reprogram writes, so a held
  // level produces one write. A zero value would make a countdown expire
  // immediately, so it is dropped and the old value kept.
  always_comb begin
    params_d = params_q;
    if (param_wr) begin
      params_d[bus.time_param_sel] = bus.time_value;
    end
  end

  // Countdown next-state. Start reads params_q, i.e. the value before any
  // write happening in the same cycle, and outranks tick/expiry/DONE.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (bus.start_timer) begin
      remaining_d = params_q[bus.interval];
      state_d     = ST_COUNT;
    end else begin
      case (state_q)
        ST_COUNT: begin
          if (one_hz) begin
            remaining_d = sat_dec(remaining_q);
            if (remaining_q <= 4'd1) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
    expired_d = (state_d == ST_DONE);
    busy_d    = (state_d == ST_COUNT);
  end

  // FSM, registered outputs, reprogram edge detector and parameter store.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= 4'd0;
      expired_q   <= 1'b0;
      busy_q      <= 1'b0;
      reprog_q    <= 1'b0;
      for (int i = 0; i < NUM_PARAMS; i++) begin
        params_q[i] <= default_param(2'(i));
      end
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      expired_q   <= expired_d;
      busy_q      <= busy_d;
      reprog_q    <= bus.reprogram;
      params_q    <= params_d;
    end
  end

  assign bus.expired        = expired_q;
  assign bus.busy           = busy_q;
  assign bus.one_hz_enable  = one_hz;
  assign bus.half_hz_enable = half_hz;
  assign bus.value_display  = (state_q == ST_IDLE) ? params_q[bus.interval]
                                                    : remaining_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_ctrl
//   Self-checking bench for countdown_ctrl with CLK_HZ=4. Expected values are
//   queued when stimulus is applied and popped when the DUT responds.
// -----------------------------------------------------------------------------
module tb_countdown_ctrl;

  localparam int CLK_HZ  = 4;
  localparam int TIMEOUT = 300;

  logic clock = 1'b0;
  logic reset = 1'b1;

  countdown_ctrl_if bus ();

  countdown_ctrl #(
    .CLK_HZ (CLK_HZ)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   checks_total  = 0;
  int   checks_passed = 0;
  int   model_params[4];
  int   exp_latency_q[$];
  int   exp_display_q[$];
  logic exp_half_q[$];

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_model();
    model_params = '{6, 8, 15, 10};
  endtask

  // Drive a one-cycle start; returns just after the edge that sampled it.
  task automatic do_start(input logic [1:0] intv);
    bus.interval    = intv;
    bus.start_timer = 1'b1;
    tick();
    bus.start_timer = 1'b0;
  endtask

  // Bounded wait for expired; lat counts edges after the start edge.
  task automatic wait_for_expired(output int lat);
    lat = 0;
    while (bus.expired !== 1'b1 && lat < TIMEOUT) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    int got;
    int exp;
    bus.start_timer    = 1'b0;
    bus.interval       = 2'd0;
    bus.reprogram      = 1'b0;
    bus.time_param_sel = 2'd0;
    bus.time_value     = 4'd0;
    reset = 1'b1;
    tick();
    tick();
    reset_model();
    checks_total++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", bus.busy);
    else checks_passed++;
    checks_total++;
    if (bus.expired !== 1'b0) $display("[TB] FAIL reset_expired: got %0b expected 0", bus.expired);
    else checks_passed++;
    checks_total++;
    if (bus.one_hz_enable !== 1'b0) $display("[TB] FAIL reset_one_hz: got %0b expected 0", bus.one_hz_enable);
    else checks_passed++;
    checks_total++;
    if (bus.half_hz_enable !== 1'b0) $display("[TB] FAIL reset_half_hz: got %0b expected 0", bus.half_hz_enable);
    else checks_passed++;
    for (int i = 0; i < 4; i++) exp_display_q.push_back(model_params[i]);
    for (int i = 0; i < 4; i++) begin
      bus.interval = 2'(i);
      #1;
      got = bus.value_display;
      exp = exp_display_q.pop_front();
      checks_total++;
      if (got !== exp) $display("[TB] FAIL reset_param%0d: got %0d expected %0d", i, got, exp);
      else checks_passed++;
    end
    bus.interval = 2'd0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_countdown();
    int lat;
    int got;
    int prev;
    int exp;
    for (int v = model_params[0]; v >= 0; v--) exp_display_q.push_back(v);
    exp_latency_q.push_back(model_params[0] * CLK_HZ + 1);
    do_start(2'd0);
    checks_total++;
    if (bus.busy !== 1'b1) $display("[TB] FAIL basic_busy: got %0b expected 1", bus.busy);
    else checks_passed++;
    prev = bus.value_display;
    exp  = exp_display_q.pop_front();
    checks_total++;
    if (prev !== exp) $display("[TB] FAIL basic_display: got %0d expected %0d", prev, exp);
    else checks_passed++;
    lat = 0;
    while (bus.expired !== 1'b1 && lat < TIMEOUT) begin
      tick();
      lat++;
      got = bus.value_display;
      if (got != prev) begin
        exp  = (exp_display_q.size() > 0) ? exp_display_q.pop_front() : -1;
        prev = got;
        checks_total++;
        if (got !== exp) $display("[TB] FAIL basic_display: got %0d expected %0d", got, exp);
        else checks_passed++;
      end
    end
    exp = exp_latency_q.pop_front();
    checks_total++;
    if (lat + 1 !== exp) $display("[TB] FAIL basic_latency: got %0d expected %0d", lat + 1, exp);
    else checks_passed++;
    checks_total++;
    if (exp_display_q.size() != 0) $display("[TB] FAIL basic_display_count: got %0d values missing expected 0", exp_display_q.size());
    else checks_passed++;
    exp_display_q.delete();
    tick();
    checks_total++;
    if (bus.expired !== 1'b0) $display("[TB] FAIL basic_pulse_width: got %0b expected 0", bus.expired);
    else checks_passed++;
    checks_total++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL basic_idle_busy: got %0b expected 0", bus.busy);
    else checks_passed++;
  endtask

  task automatic test_reprogram_once();
    int lat;
    int got;
    int exp;
    bus.time_param_sel = 2'd2;
    bus.time_value     = 4'd3;
    bus.reprogram      = 1'b1;
    tick();
    model_params[2] = 3;
    // A second write while held would store 9.
    bus.time_value = 4'd9;
    repeat (9) tick();
    bus.reprogram  = 1'b0;
    bus.time_value = 4'd0;
    tick();
    bus.interval = 2'd2;
    #1;
    got = bus.value_display;
    checks_total++;
    if (got !== model_params[2]) $display("[TB] FAIL reprog_value: got %0d expected %0d", got, model_params[2]);
    else checks_passed++;
    exp_latency_q.push_back(model_params[2] * CLK_HZ + 1);
    do_start(2'd2);
    wait_for_expired(lat);
    exp = exp_latency_q.pop_front();
    checks_total++;
    if (lat + 1 !== exp) $display("[TB] FAIL reprog_latency: got %0d expected %0d", lat + 1, exp);
    else checks_passed++;
    tick();
  endtask

  task automatic test_zero_write_ignored();
    int lat;
    int got;
    int exp;
    bus.time_param_sel = 2'd1;
    bus.time_value     = 4'd0;
    bus.reprogram      = 1'b1;
    tick();
    bus.reprogram = 1'b0;
    tick();
    bus.interval = 2'd1;
    #1;
    got = bus.value_display;
    checks_total++;
    if (got !== model_params[1]) $display("[TB] FAIL zero_write_value: got %0d expected %0d", got, model_params[1]);
    else checks_passed++;
    exp_latency_q.push_back(model_params[1] * CLK_HZ + 1);
    do_start(2'd1);
    wait_for_expired(lat);
    exp = exp_latency_q.pop_front();
    checks_total++;
    if (lat + 1 !== exp) $display("[TB] FAIL zero_write_latency: got %0d expected %0d", lat + 1, exp);
    else checks_passed++;
    tick();
  endtask

  task automatic test_start_with_reprogram();
    int lat;
    int got;
    int exp;
    int old_val;
    old_val = model_params[0];
    exp_latency_q.push_back(old_val * CLK_HZ + 1);
    bus.time_param_sel = 2'd0;
    bus.time_value     = 4'd2;
    bus.reprogram      = 1'b1;
    bus.interval       = 2'd0;
    bus.start_timer    = 1'b1;
    tick();
    bus.start_timer = 1'b0;
    bus.reprogram   = 1'b0;
    model_params[0] = 2;
    got = bus.value_display;
    checks_total++;
    if (got !== old_val) $display("[TB] FAIL same_cycle_load: got %0d expected %0d", got, old_val);
    else checks_passed++;
    wait_for_expired(lat);
    exp = exp_latency_q.pop_front();
    checks_total++;
    if (lat + 1 !== exp) $display("[TB] FAIL same_cycle_latency: got %0d expected %0d", lat + 1, exp);
    else checks_passed++;
    tick();
    got = bus.value_display;
    checks_total++;
    if (got !== model_params[0]) $display("[TB] FAIL same_cycle_newval: got %0d expected %0d", got, model_params[0]);
    else checks_passed++;
    exp_latency_q.push_back(model_params[0] * CLK_HZ + 1);
    do_start(2'd0);
    wait_for_expired(lat);
    exp = exp_latency_q.pop_front();
    checks_total++;
    if (lat + 1 !== exp) $display("[TB] FAIL next_start_latency: got %0d expected %0d", lat + 1, exp);
    else checks_passed++;
    tick();
  endtask

  task automatic test_restart();
    int lat;
    int got;
    int exp;
    int extra;
    do_start(2'd3);
    repeat (2 * CLK_HZ) tick();
    got = bus.value_display;
    checks_total++;
    if (got !== model_params[3] - 2) $display("[TB] FAIL restart_two_ticks: got %0d expected %0d", got, model_params[3] - 2);
    else checks_passed++;
    exp_latency_q.push_back(model_params[3] * CLK_HZ + 1);
    do_start(2'd3);
    got = bus.value_display;
    checks_total++;
    if (got !== model_params[3]) $display("[TB] FAIL restart_reload: got %0d expected %0d", got, model_params[3]);
    else checks_passed++;
    wait_for_expired(lat);
    exp = exp_latency_q.pop_front();
    checks_total++;
    if (lat + 1 !== exp) $display("[TB] FAIL restart_latency: got %0d expected %0d", lat + 1, exp);
    else checks_passed++;
    extra = 0;
    repeat (50) begin
      tick();
      if (bus.expired === 1'b1) extra++;
    end
    checks_total++;
    if (extra !== 0) $display("[TB] FAIL restart_extra_expired: got %0d expected 0", extra);
    else checks_passed++;
  endtask

  task automatic test_start_on_tick_and_reset();
    int n;
    int got;
    int extra;
    n = 0;
    while (bus.one_hz_enable !== 1'b1 && n < TIMEOUT) begin
      tick();
      n++;
    end
    checks_total++;
    if (bus.one_hz_enable !== 1'b1) $display("[TB] FAIL tick_search: got %0b expected 1", bus.one_hz_enable);
    else checks_passed++;
    do_start(2'd3);
    got = bus.value_display;
    checks_total++;
    if (got !== model_params[3]) $display("[TB] FAIL start_on_tick: got %0d expected %0d", got, model_params[3]);
    else checks_passed++;
    n = 0;
    while (bus.value_display !== 4'd4 && n < TIMEOUT) begin
      tick();
      n++;
    end
    checks_total++;
    if (n !== (model_params[3] - 4) * CLK_HZ) $display("[TB] FAIL reach_four: got %0d cycles expected %0d", n, (model_params[3] - 4) * CLK_HZ);
    else checks_passed++;
    reset = 1'b1;
    tick();
    reset_model();
    checks_total++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %0b expected 0", bus.busy);
    else checks_passed++;
    got = bus.value_display;
    checks_total++;
    if (got !== model_params[3]) $display("[TB] FAIL midreset_display: got %0d expected %0d", got, model_params[3]);
    else checks_passed++;
    reset = 1'b0;
    extra = 0;
    repeat (60) begin
      tick();
      if (bus.expired === 1'b1) extra++;
    end
    checks_total++;
    if (extra !== 0) $display("[TB] FAIL midreset_expired: got %0d expected 0", extra);
    else checks_passed++;
  endtask

  task automatic test_free_run();
    int last_tick;
    int ticks;
    logic exp;
    last_tick = -1;
    ticks     = 0;
    exp_half_q.delete();
    for (int c = 0; c < 16; c++) begin
      tick();
      if (exp_half_q.size() > 0) begin
        exp = exp_half_q.pop_front();
        checks_total++;
        if (bus.half_hz_enable !== exp) $display("[TB] FAIL half_toggle: got %0b expected %0b", bus.half_hz_enable, exp);
        else checks_passed++;
      end
      if (bus.one_hz_enable === 1'b1) begin
        ticks++;
        if (last_tick >= 0) begin
          checks_total++;
          if (c - last_tick !== CLK_HZ) $display("[TB] FAIL tick_spacing: got %0d expected %0d", c - last_tick, CLK_HZ);
          else checks_passed++;
        end
        last_tick = c;
        exp_half_q.push_back(~bus.half_hz_enable);
      end
    end
    exp_half_q.delete();
    checks_total++;
    if (ticks !== 16 / CLK_HZ) $display("[TB] FAIL tick_count: got %0d expected %0d", ticks, 16 / CLK_HZ);
    else checks_passed++;
  endtask

  initial begin
    test_reset();
    test_basic_countdown();
    test_reprogram_once();
    test_zero_write_ignored();
    test_start_with_reprogram();
    test_restart();
    test_start_on_tick_and_reset();
    test_free_run();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
